// File: rtl/uart_tx_port_if.sv
// rtl/uart_tx_port_if.sv - CPU store-bus snoop and UART line/status bundle for uart_tx_port
interface uart_tx_port_if;
  logic [15:0] address;
  logic [7:0]  data_write;
  logic        read_write;
  logic [7:0]  status;
  logic        tx;

  modport master (
    output address,
    output data_write,
    output read_write,
    input  status,
    input  tx
  );

  modport slave (
    input  address,
    input  data_write,
    input  read_write,
    output status,
    output tx
  );
endinterface

// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - memory-mapped FIFO-backed 8N1 UART transmitter; optional even parity via UART_TX_PARITY_EN
module uart_tx_port #(
  parameter int          CLKS_PER_BIT = 4,
  parameter int          DEPTH        = 4,
  parameter logic [15:0] TX_ADDR      = 16'h00FD,
  parameter logic [15:0] STATUS_ADDR  = 16'h00FC
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_port_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t             r_state;
  logic [BAUD_W-1:0]  r_baud;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic [7:0]         r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`endif

  state_t             w_state_next;
  logic [BAUD_W-1:0]  w_baud_next;
  logic [2:0]         w_bit_next;
  logic [7:0]         w_shift_next;
  logic               w_tx_next;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_store_tx;
  logic               w_store_status;
  logic               w_full;
  logic               w_empty;
  logic               w_baud_done;

  assign w_store_tx     = bus.read_write && (bus.address == TX_ADDR);
  assign w_store_status = bus.read_write && (bus.address == STATUS_ADDR);
  assign w_full         = (r_count == CNT_W'(DEPTH));
  assign w_empty        = (r_count == '0);
  assign w_baud_done    = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

  // A full FIFO still accepts a store when the FSM pops on the same edge.
  assign w_push = w_store_tx && (!w_full || w_pop);
  assign w_drop = w_store_tx && w_full && !w_pop;

  assign bus.status = {4'b0000, r_overflow, (r_state != S_IDLE), w_empty, w_full};
  assign bus.tx     = r_tx;

  // Next-state, baud/bit counters, shifter and registered-tx value for the frame FSM.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_tx_next    = 1'b1;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_bit_next   = 3'd0;
          w_baud_next  = '0;
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_state_next = S_DATA;
          w_tx_next    = r_shift[0];
        end else begin
          w_baud_next  = r_baud + BAUD_W'(1);
          w_tx_next    = 1'b0;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_tx_next    = r_parity;
`else
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_bit_next   = r_bit_cnt + 3'd1;
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_baud_next  = r_baud + BAUD_W'(1);
          w_tx_next    = r_shift[0];
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_state_next = S_STOP;
          w_tx_next    = 1'b1;
        end else begin
          w_baud_next  = r_baud + BAUD_W'(1);
          w_tx_next    = r_parity;
        end
      end
`endif
      S_STOP: begin
        w_tx_next = 1'b1;
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_state_next = S_IDLE;
        end else begin
          w_baud_next  = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_baud_next  = '0;
      end
    endcase
  end

  // FSM state, shifter and line register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_cnt <= w_bit_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte, captured as it leaves the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= ^w_shift_next;
    end
  end
`endif

  // FIFO storage; contents need no reset because pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.data_write;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: set on a dropped store, cleared by a store to the status address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_store_status) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - directed table-driven bench for uart_tx_port (CLKS_PER_BIT=4, DEPTH=4)
module tb_uart_tx_port;

  localparam logic [15:0] TXA = 16'h00FD;
  localparam logic [15:0] STA = 16'h00FC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_port_if bus ();

  uart_tx_port #(
    .CLKS_PER_BIT(4),
    .DEPTH(4),
    .TX_ADDR(TXA),
    .STATUS_ADDR(STA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  logic [7:0] rx_q [$];
  int         rx_t [$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs [5];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_store(input logic [15:0] a, input logic [7:0] d);
    bus.address    = a;
    bus.data_write = d;
    bus.read_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.read_write = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (bus.status[2:0] !== 3'b010 && t < 400) begin
      cyc(1);
      t++;
    end
    if (t >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout waiting for idle, status %0h", name, bus.status);
    end
  endtask

  // Line monitor: decodes frames by mid-bit sampling, dropping any frame cut by reset.
  initial begin
    logic [7:0] b;
    bit ab;
    int t0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.tx === 1'b0) begin
        t0 = cyc_n;
        ab = 1'b0;
        b  = 8'h00;
        for (int i = 1; i <= 38; i++) begin
          @(negedge clk);
          if (rst !== 1'b1) ab = 1'b1;
          if (i >= 6 && i <= 34 && (i % 4) == 2) b[(i - 6) / 4] = bus.tx;
          if (i == 38 && bus.tx !== 1'b1) ab = 1'b1;
        end
        if (!ab) begin
          rx_q.push_back(b);
          rx_t.push_back(t0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit quiet;
    int t;

    vecs[0] = '{data: 8'hA5, frame: 10'b0101001011};
    vecs[1] = '{data: 8'h00, frame: 10'b0000000001};
    vecs[2] = '{data: 8'hFF, frame: 10'b0111111111};
    vecs[3] = '{data: 8'h01, frame: 10'b0100000001};
    vecs[4] = '{data: 8'h3C, frame: 10'b0001111001};

    // Reset held with a live store request on the bus.
    bus.address    = TXA;
    bus.data_write = 8'hEE;
    bus.read_write = 1'b1;
    rst            = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("rst_tx", bus.tx, 1);
      check("rst_status", bus.status, 8'h02);
    end
    rst            = 1'b1;
    bus.read_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("post_rst_tx", bus.tx, 1);
      check("post_rst_status", bus.status, 8'h02);
    end

    // Table-driven single frames, checked every cycle.
    for (int v = 0; v < 5; v++) begin
      do_store(TXA, vecs[v].data);
      check("store_status", bus.status, 8'h00);
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 4; c++) begin
          cyc(1);
          if (b == 0 && c == 0) check("busy_status", bus.status, 8'h06);
          check($sformatf("frame%0d_bit%0d", v, b), bus.tx, vecs[v].frame[9 - b]);
        end
      end
      cyc(1);
      check("done_status", bus.status, 8'h02);
      check("done_tx", bus.tx, 1);
    end

    // Fill and overflow.
    cyc(2);
    rx_q.delete();
    rx_t.delete();
    bus.read_write = 1'b1;
    bus.address    = TXA;
    for (int i = 1; i <= 6; i++) begin
      bus.data_write = 8'(i);
      cyc(1);
      if (i == 5) check("fill_full_status", bus.status, 8'h05);
      if (i == 6) check("fill_ovf_status", bus.status, 8'h0D);
    end
    bus.read_write = 1'b0;
    wait_idle("fill_idle");
    cyc(2);
    check("fill_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      check("fill_rx_byte", rx_q[i], i + 1);
    end
    if (rx_t.size() >= 2) check("b2b_spacing", rx_t[1] - rx_t[0], 41);
    check("fill_end_status", bus.status, 8'h0A);

    // Overflow clear and address/direction decode.
    do_store(STA, 8'hFF);
    check("ovf_clear_status", bus.status, 8'h02);
    do_store(16'h00FE, 8'h55);
    check("bad_addr_status", bus.status, 8'h02);
    bus.address    = TXA;
    bus.data_write = 8'h66;
    bus.read_write = 1'b0;
    cyc(1);
    check("read_access_status", bus.status, 8'h02);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (bus.tx !== 1'b1 || bus.status !== 8'h02) quiet = 1'b0;
    end
    check("decode_quiet", quiet, 1);

    // Simultaneous push and pop while full.
    rx_q.delete();
    rx_t.delete();
    bus.read_write = 1'b1;
    bus.address    = TXA;
    for (int i = 0; i < 5; i++) begin
      bus.data_write = 8'h10 + 8'(i);
      cyc(1);
    end
    bus.read_write = 1'b0;
    check("pp_full_status", bus.status, 8'h05);
    t = 0;
    while (bus.status !== 8'h01 && t < 80) begin
      cyc(1);
      t++;
    end
    check("pp_idle_full_seen", bus.status, 8'h01);
    do_store(TXA, 8'h15);
    check("pp_accept_status", bus.status, 8'h05);
    wait_idle("pp_idle");
    cyc(2);
    check("pp_rx_count", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      check("pp_rx_byte", rx_q[i], 8'h10 + i);
    end
    check("pp_end_status", bus.status, 8'h02);

    // Reset in the middle of data bit 3.
    rx_q.delete();
    do_store(TXA, 8'hA5);
    cyc(18);
    check("mid_pre_tx", bus.tx, 0);
    check("mid_pre_status", bus.status, 8'h06);
    rst = 1'b0;
    cyc(1);
    check("mid_rst_tx", bus.tx, 1);
    check("mid_rst_status", bus.status, 8'h02);
    cyc(1);
    rst = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (bus.tx !== 1'b1) quiet = 1'b0;
    end
    check("mid_no_frame", quiet, 1);
    check("mid_rx_count", rx_q.size(), 0);
    check("mid_end_status", bus.status, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped serial transmitter on the CPU write path. It is the output-direction counterpart to the read-side peripheral multiplexer that feeds the CPU. The block snoops the CPU address, data and write-enable bus; when the CPU stores to the TX data address, it queues the byte in a small FIFO. It then serialises each byte onto an 8N1 UART line. A status byte is presented for the read multiplexer so software can poll full, empty, busy and overflow.

## Interface
- CLKS_PER_BIT, 4: clk cycles per serial bit; legal values are ≥2.
- DEPTH, 4: FIFO entries; must be a power of two, ≥2.
- TX_ADDR, 16'h00FD: CPU store address that enqueues a byte.
- STATUS_ADDR, 16'h00FC: CPU store address that clears the sticky overflow flag.
- clk  input  1  sole clock; in the system this is the CPU clock.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- address  input  16  CPU address bus.
- data_write  input  8  CPU write data.
- read_write  input  1  CPU write enable; 1 means store.
- status  output  8  {4'b0, overflow, busy, empty, full}; registered state, no combinational path from inputs.
- tx  output  1  serial line; idles high.

## Operation
- Store decode:
  - A store is read_write=1 with address==TX_ADDR, sampled on a rising clk edge.
  - Any other address or read_write=0 is ignored.
  - Stores to STATUS_ADDR clear overflow; the data value is ignored.
- FIFO:
  - Circular buffer with ptr widths of $clog2(DEPTH), plus a count of width $clog2(DEPTH)+1.
  - full = (count==DEPTH); empty = (count==0).
  - Pointers wrap modulo DEPTH.
- Push when full:
  - The byte is dropped and overflow is set. overflow is sticky until reset or a STATUS_ADDR store.
  - Exception: if a pop occurs on the same edge, the push is accepted and the count stays at DEPTH.
- Simultaneous push and pop on a non-full FIFO: both happen and the count is unchanged.
- Pop on empty: never issued. The FSM only pops when empty=0.
- Transmitter FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If empty=0, pop the head byte into the shift register, clear the bit counter and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After 8 bits, LSB first, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- busy = (state != IDLE).
- Baud counter runs 0..CLKS_PER_BIT-1 and resets on every state or bit change.
- Reset mid-frame abandons the frame: tx returns high on the next edge and the FIFO contents are discarded.

## Timing
- Reset values:
  - tx=1, state=IDLE, count=0, pointers=0, overflow=0.
  - status=8'h02.
- A store on edge N is reflected in status at edge N.
- With an empty FIFO and IDLE, the FSM pops at edge N+1. tx goes low after edge N+1, so the first start bit starts 1 cycle after the store edge.
- One frame occupies 10*CLKS_PER_BIT cycles from tx falling to the end of stop.
- IDLE lasts at least 1 cycle between frames. Back-to-back throughput is therefore one byte per 10*CLKS_PER_BIT+1 cycles.
- tx is registered and glitch-free.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (^byte) for CLKS_PER_BIT cycles, and the frame becomes 11*CLKS_PER_BIT cycles.
  - Undefined: no PARITY state and the frame is 8N1. This is the default build.

## Test plan
- Reset: hold rst=0 for 3 cycles with read_write=1 and address=TX_ADDR. Response: tx=1 and status=8'h02 throughout; no byte is queued after release.
- Single byte, CLKS_PER_BIT=4: store 8'hA5 at TX_ADDR. Response:
  - tx is low for 4 cycles starting 1 cycle after the store.
  - The data bits are 1,0,1,0,0,1,0,1, 4 cycles each.
  - tx is high for 4 stop cycles, and busy returns to 0 at cycle 41.
- Fill and overflow: store 8'h01..8'h06 on consecutive cycles. Response:
  - 8'h01 is popped immediately and 8'h02..8'h05 fill the FIFO, so full=1.
  - 8'h06 is dropped and overflow=1.
  - The line carries 01,02,03,04,05 in order.
- Simultaneous push/pop at full: with count=DEPTH, store a byte on the edge the FSM leaves STOP for IDLE and pops. Response: the byte is accepted, count stays at 4 and overflow stays 0.
- Overflow clear and decode: store to STATUS_ADDR with overflow=1. Response: overflow=0 next edge. A store to 16'h00FE and a read_write=0 access at TX_ADDR enqueue nothing.
- Reset mid-frame: assert rst during DATA bit 3. Response: tx=1 and status=8'h02 after the edge, and no further frame is sent.
